// File: rtl/axi4_lite_mult_regif.sv
// AXI4-Lite register front-end for a multiplier core.
// Software writes operands A/B and a start command. The block drives
// m_a/m_b/m_start to the core and captures m_res once m_ready signals that
// the multiply has finished. Status and result can then be read back.
//
// Ports:
//   clk, _rst                 clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*           AXI4-Lite write address / data / response
//   s_ar*/s_r*                AXI4-Lite read address / data
//   m_a, m_b, m_start         operands and one-cycle start pulse to the core
//   m_res, m_ready            result and completion/idle flag from the core
//
// Register map (byte offsets, address bits [4:2] decoded):
//   0x00 A, 0x04 B (RW, SZ bits), 0x08 CTRL/STAT, 0x0C RES_LO, 0x10 RES_HI
module axi4_lite_mult_regif #(
    parameter int unsigned SZ     = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [SZ-1:0]     m_a,
    output logic [SZ-1:0]     m_b,
    output logic              m_start,
    input  logic [2*SZ-1:0]   m_res,
    input  logic              m_ready
);

    localparam int unsigned RES_W = 2 * SZ;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [2:0]  IDX_A       = 3'd0;
    localparam logic [2:0]  IDX_B       = 3'd1;
    localparam logic [2:0]  IDX_CTRL    = 3'd2;
    localparam logic [2:0]  IDX_RES_LO  = 3'd3;
    localparam logic [2:0]  IDX_RES_HI  = 3'd4;

    // write channel state
    logic              r_awready, r_wready, r_aw_held, r_w_held;
    logic [2:0]        r_aw_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    // read channel state
    logic              r_arready, r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    // register file and multiplier control
    logic [SZ-1:0]     r_a, r_b;
    logic [RES_W-1:0]  r_res;
    logic              r_busy, r_done, r_ovr, r_start;
    logic [1:0]        r_guard;

    logic              w_aw_hs, w_w_hs, w_wr_fire;
    logic [2:0]        w_wr_idx;
    logic [31:0]       w_wr_data, w_wmask;
    logic [3:0]        w_wr_strb;
    logic [SZ-1:0]     w_a_next, w_b_next;
    logic              w_wr_a, w_wr_b, w_ctrl, w_start, w_ovr_set, w_capture;
    logic [1:0]        w_bresp;
    logic              w_ar_hs;
    logic [31:0]       w_rd_data;
    logic [1:0]        w_rd_resp;
    logic [63:0]       w_res_ext;
    logic              w_unused_addr;

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign m_a       = r_a;
    assign m_b       = r_b;
    assign m_start   = r_start;

    // only address bits [4:2] select a register
    assign w_unused_addr = ^{s_awaddr, s_araddr};

    // AW and W may arrive in either order; the write commits once both are present
    assign w_aw_hs   = s_awvalid & r_awready;
    assign w_w_hs    = s_wvalid & r_wready;
    assign w_wr_idx  = r_aw_held ? r_aw_idx : s_awaddr[4:2];
    assign w_wr_data = r_w_held ? r_wdata : s_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_wstrb;
    assign w_wr_fire = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    // byte-strobe merge for the operand registers
    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            w_wmask[8*i +: 8] = {8{w_wr_strb[i]}};
        end
        w_a_next = SZ'((32'(r_a) & ~w_wmask) | (w_wr_data & w_wmask));
        w_b_next = SZ'((32'(r_b) & ~w_wmask) | (w_wr_data & w_wmask));
    end

    // write decode; operands are locked while a multiply is in flight
    always_comb begin
        w_wr_a    = 1'b0;
        w_wr_b    = 1'b0;
        w_ctrl    = 1'b0;
        w_bresp   = RESP_SLVERR;
        case (w_wr_idx)
            IDX_A: begin
                w_wr_a  = w_wr_fire & ~r_busy;
                w_bresp = r_busy ? RESP_SLVERR : RESP_OKAY;
            end
            IDX_B: begin
                w_wr_b  = w_wr_fire & ~r_busy;
                w_bresp = r_busy ? RESP_SLVERR : RESP_OKAY;
            end
            IDX_CTRL: begin
                w_ctrl  = w_wr_fire & w_wr_strb[0];
                w_bresp = RESP_OKAY;
            end
            default: w_bresp = RESP_SLVERR;
        endcase
        w_start   = w_ctrl & w_wr_data[0] & ~r_busy;
        w_ovr_set = w_ctrl & w_wr_data[0] & r_busy;
    end

    // m_ready is stale during the start pulse and the cycle after it
    assign w_capture = r_busy & m_ready & (r_guard == 2'd0);

    // write channel handshakes and response
    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_wr_fire) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_bresp;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_awaddr[4:2];
                r_awready <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
                r_wready <= 1'b0;
            end
            if (r_bvalid && s_bready) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // operand, status and result registers
    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_start <= 1'b0;
            r_guard <= '0;
        end else begin
            if (w_wr_a) r_a <= w_a_next;
            if (w_wr_b) r_b <= w_b_next;
            r_start <= w_start;
            if (w_start) begin
                r_guard <= 2'd2;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_capture) begin
                r_busy <= 1'b0;
            end
            // capture beats a same-cycle W1C; a start clears done
            if (w_capture) begin
                r_done <= 1'b1;
            end else if (w_start || (w_ctrl && w_wr_data[1])) begin
                r_done <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_ctrl && w_wr_data[2]) begin
                r_ovr <= 1'b0;
            end
            if (w_capture) r_res <= m_res;
        end
    end

    // read data mux, sampled at the AR handshake
    assign w_ar_hs   = s_arvalid & r_arready;
    assign w_res_ext = 64'(r_res);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (s_araddr[4:2])
            IDX_A:      w_rd_data = 32'(r_a);
            IDX_B:      w_rd_data = 32'(r_b);
            IDX_CTRL:   w_rd_data = {29'b0, r_ovr, r_done, r_busy};
            IDX_RES_LO: w_rd_data = w_res_ext[31:0];
            IDX_RES_HI: w_rd_data = w_res_ext[63:32];
            default:    w_rd_resp = RESP_SLVERR;
        endcase
    end

    // read channel: one outstanding read, data held until accepted
    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
        end else if (r_rvalid && s_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_lite_mult_regif.sv
// Self-checking bench for axi4_lite_mult_regif: a vector table of register
// accesses, hand-written multi-cycle sequences, and randomized multiplies
// checked against a simple arithmetic reference model.
module tb_axi4_lite_mult_regif;

    localparam int unsigned SZ     = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              _rst;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid, s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid, s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid, s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid, s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid, s_rready;
    logic [SZ-1:0]     m_a, m_b;
    logic              m_start;
    logic [2*SZ-1:0]   m_res;
    logic              m_ready;

    axi4_lite_mult_regif #(.SZ(SZ), .ADDR_W(ADDR_W)) dut (
        .clk(clk), ._rst(_rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_a(m_a), .m_b(m_b), .m_start(m_start), .m_res(m_res), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // multiplier core model: ready drops after start, returns tb_lat cycles later
    int unsigned tb_lat = 4;
    int unsigned mul_cnt;
    logic [63:0] mul_prod;
    always @(posedge clk or posedge _rst) begin
        if (_rst) begin
            m_ready  <= 1'b1;
            mul_cnt  <= 0;
            mul_prod <= '0;
        end else if (m_start) begin
            m_ready  <= 1'b0;
            mul_cnt  <= tb_lat;
            mul_prod <= 64'(m_a) * 64'(m_b);
        end else if (mul_cnt != 0) begin
            if (mul_cnt == 1) m_ready <= 1'b1;
            mul_cnt <= mul_cnt - 1;
        end
    end
    // garbage on the result bus until the core reports completion
    assign m_res = m_ready ? mul_prod : ~mul_prod;

    // start pulse monitor
    int          start_cnt  = 0;
    int          start_long = 0;
    logic        prev_start = 1'b0;
    logic [SZ-1:0] st_a, st_b;
    always @(posedge clk) begin
        if (m_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            st_a      <= m_a;
            st_b      <= m_b;
            if (prev_start) start_long <= start_long + 1;
        end
        prev_start <= (m_start === 1'b1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, awr, wr, bv;
        int   t;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            awr = s_awready; wr = s_wready;
            @(posedge clk); #1;
            if (awr && s_awvalid) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (wr && s_wvalid)   begin w_done = 1'b1;  s_wvalid = 1'b0;  end
            t++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout_fail("write_addr_data");
        s_bready = 1'b1; bv = 1'b0; t = 0; resp = 2'b11;
        while (!bv && t < 50) begin
            bv = s_bvalid; resp = s_bresp;
            @(posedge clk); #1;
            t++;
        end
        s_bready = 1'b0;
        if (!bv) timeout_fail("write_resp");
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic arr, rv;
        int   t;
        s_araddr = addr; s_arvalid = 1'b1; arr = 1'b0; t = 0;
        while (!arr && t < 50) begin
            arr = s_arready;
            @(posedge clk); #1;
            t++;
        end
        s_arvalid = 1'b0;
        if (!arr) timeout_fail("read_addr");
        s_rready = 1'b1; rv = 1'b0; t = 0; data = '0; resp = 2'b11;
        while (!rv && t < 50) begin
            rv = s_rvalid; data = s_rdata; resp = s_rresp;
            @(posedge clk); #1;
            t++;
        end
        s_rready = 1'b0;
        if (!rv) timeout_fail("read_data");
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic wr_chk(input string name, input logic [4:0] addr, input logic [31:0] data,
                          input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, 4'hf, r);
        chk(name, 64'(r), 64'(exp_resp));
    endtask

    // poll STAT until busy clears; returns the final status word
    task automatic wait_idle(output logic [31:0] stat);
        logic [1:0] r;
        int         n;
        stat = 32'h1; n = 0;
        while (stat[0] && n < 40) begin
            axi_read(5'h08, stat, r);
            n++;
        end
        if (stat[0]) timeout_fail("wait_idle");
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[$];
        logic [31:0] d, stat;
        logic [1:0]  r;
        int          s0;
        logic [31:0] a_mdl, b_mdl, wa, wb;
        logic [3:0]  sa, sb;
        logic [63:0] prod;
        logic        extra;

        _rst = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        // access table, applied from reset state
        tbl.push_back('{1'b1, 5'h00, 32'h0000_0007, 4'hf, 2'b00, 32'h0});
        tbl.push_back('{1'b1, 5'h04, 32'h0000_0006, 4'hf, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0007});
        tbl.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 2'b00, 32'h0000_0006});
        tbl.push_back('{1'b1, 5'h00, 32'hAABB_CCDD, 4'h1, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_00DD});
        tbl.push_back('{1'b1, 5'h00, 32'h1234_5678, 4'hc, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h1234_00DD});
        tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h1234_00DD});
        tbl.push_back('{1'b1, 5'h0C, 32'h0000_0001, 4'hf, 2'b10, 32'h0});
        tbl.push_back('{1'b1, 5'h10, 32'h0000_0001, 4'hf, 2'b10, 32'h0});
        tbl.push_back('{1'b1, 5'h14, 32'h0000_0001, 4'hf, 2'b10, 32'h0});
        tbl.push_back('{1'b0, 5'h0C, 32'h0,         4'h0, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h10, 32'h0,         4'h0, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h14, 32'h0,         4'h0, 2'b10, 32'h0});
        tbl.push_back('{1'b0, 5'h1C, 32'h0,         4'h0, 2'b10, 32'h0});
        tbl.push_back('{1'b1, 5'h08, 32'h0000_0001, 4'he, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h08, 32'h0,         4'h0, 2'b00, 32'h0});
        tbl.push_back('{1'b1, 5'h00, 32'h0000_0007, 4'hf, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0007});

        // reset asserted mid-cycle
        repeat (2) @(posedge clk);
        #3 _rst = 1'b1;
        #1;
        chk("rst_readies", 64'({s_awready, s_wready, s_arready}), 64'(3'b111));
        chk("rst_valids",  64'({s_bvalid, s_rvalid, m_start}), 64'(3'b000));
        chk("rst_resps",   64'({s_bresp, s_rresp}), 64'(4'b0000));
        chk("rst_rdata",   64'(s_rdata), 64'(0));
        chk("rst_operands", 64'({m_a, m_b}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) _rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_stat",   5'h08, 32'h0);
        rd_chk("rst_res_lo", 5'h0C, 32'h0);
        rd_chk("rst_res_hi", 5'h10, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), 64'(r), 64'(tbl[i].exp_resp));
            end else begin
                axi_read(tbl[i].addr, d, r);
                chk($sformatf("vec%0d_rresp", i), 64'(r), 64'(tbl[i].exp_resp));
                chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(tbl[i].exp_data));
            end
        end
        chk("no_start_from_table", 64'(start_cnt), 64'(0));

        // 7 x 6
        s0 = start_cnt;
        wr_chk("mul42_ctrl", 5'h08, 32'h1, 2'b00);
        rd_chk("mul42_stat_busy", 5'h08, 32'h1);
        chk("mul42_one_start", 64'(start_cnt - s0), 64'(1));
        chk("mul42_start_ops", 64'({st_a, st_b}), {32'd7, 32'd6});
        wait_idle(stat);
        chk("mul42_stat_done", 64'(stat), 64'(2));
        rd_chk("mul42_res_lo", 5'h0C, 32'd42);
        rd_chk("mul42_res_hi", 5'h10, 32'd0);

        // all-ones operands; start also clears the previous done
        wr_chk("max_a", 5'h00, 32'hFFFF_FFFF, 2'b00);
        wr_chk("max_b", 5'h04, 32'hFFFF_FFFF, 2'b00);
        wr_chk("max_ctrl", 5'h08, 32'h1, 2'b00);
        rd_chk("max_stat_busy", 5'h08, 32'h1);
        wait_idle(stat);
        chk("max_stat_done", 64'(stat), 64'(2));
        rd_chk("max_res_lo", 5'h0C, 32'h0000_0001);
        rd_chk("max_res_hi", 5'h10, 32'hFFFF_FFFE);

        // back-to-back starts: second one is an overrun
        wr_chk("ovr_a", 5'h00, 32'd9, 2'b00);
        wr_chk("ovr_b", 5'h04, 32'd11, 2'b00);
        s0 = start_cnt;
        wr_chk("ovr_ctrl1", 5'h08, 32'h1, 2'b00);
        wr_chk("ovr_ctrl2", 5'h08, 32'h1, 2'b00);
        wait_idle(stat);
        chk("ovr_one_start", 64'(start_cnt - s0), 64'(1));
        chk("ovr_stat", 64'(stat), 64'(6));
        rd_chk("ovr_res_lo", 5'h0C, 32'd99);
        wr_chk("ovr_clr", 5'h08, 32'h4, 2'b00);
        rd_chk("ovr_stat_clr", 5'h08, 32'h2);
        wr_chk("done_clr", 5'h08, 32'h2, 2'b00);
        rd_chk("done_stat_clr", 5'h08, 32'h0);

        // AW three cycles ahead of W, response back-pressured
        s_awaddr = 5'h00; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        chk("skew_aw_ready_drop", 64'({s_awready, s_wready}), 64'(2'b01));
        repeat (2) @(posedge clk);
        #1 chk("skew_no_early_b", 64'(s_bvalid), 64'(0));
        s_wdata = 32'h55; s_wstrb = 4'hf; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        chk("skew_aw_bvalid", 64'({s_bvalid, s_bresp}), 64'(3'b100));
        repeat (2) begin
            @(posedge clk); #1;
            chk("skew_aw_b_hold", 64'({s_bvalid, s_bresp, s_awready, s_wready}), 64'(5'b10000));
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        chk("skew_aw_b_done", 64'({s_bvalid, s_awready, s_wready}), 64'(3'b011));
        rd_chk("skew_aw_a", 5'h00, 32'h55);

        // W ahead of AW
        s_wdata = 32'h66; s_wstrb = 4'hf; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        chk("skew_w_ready_drop", 64'({s_awready, s_wready}), 64'(2'b10));
        repeat (2) @(posedge clk);
        s_awaddr = 5'h04; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        chk("skew_w_bvalid", 64'({s_bvalid, s_bresp}), 64'(3'b100));
        repeat (2) begin
            @(posedge clk); #1;
            chk("skew_w_b_hold", 64'({s_bvalid, s_bresp}), 64'(3'b100));
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        chk("skew_w_b_done", 64'({s_bvalid, s_awready, s_wready}), 64'(3'b011));
        rd_chk("skew_w_b", 5'h04, 32'h66);
        rd_chk("skew_w_a_kept", 5'h00, 32'h55);

        // operand writes rejected while busy
        wr_chk("busy_a0", 5'h00, 32'd3, 2'b00);
        wr_chk("busy_b0", 5'h04, 32'd5, 2'b00);
        tb_lat = 6;
        wr_chk("busy_ctrl", 5'h08, 32'h1, 2'b00);
        wr_chk("busy_wr_a", 5'h00, 32'h99, 2'b10);
        wr_chk("busy_wr_b", 5'h04, 32'h99, 2'b10);
        chk("busy_m_ops", 64'({m_a, m_b}), {32'd3, 32'd5});
        rd_chk("busy_rd_a", 5'h00, 32'd3);
        wait_idle(stat);
        rd_chk("busy_res_lo", 5'h0C, 32'd15);
        wr_chk("busy_clr", 5'h08, 32'h6, 2'b00);

        // randomized multiplies against the arithmetic model
        a_mdl = $urandom; b_mdl = $urandom;
        wr_chk("rnd_init_a", 5'h00, a_mdl, 2'b00);
        wr_chk("rnd_init_b", 5'h04, b_mdl, 2'b00);
        for (int it = 0; it < 16; it++) begin
            wa = $urandom; wb = $urandom;
            sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                if (sa[k]) a_mdl[8*k +: 8] = wa[8*k +: 8];
                if (sb[k]) b_mdl[8*k +: 8] = wb[8*k +: 8];
            end
            axi_write(5'h00, wa, sa, r);
            chk($sformatf("rnd%0d_wa", it), 64'(r), 64'(0));
            axi_write(5'h04, wb, sb, r);
            chk($sformatf("rnd%0d_wb", it), 64'(r), 64'(0));
            tb_lat = $urandom_range(1, 6);
            extra  = 1'($urandom_range(0, 1));
            axi_write(5'h08, 32'h1, 4'hf, r);
            if (extra) axi_write(5'h08, 32'h1, 4'hf, r);
            wait_idle(stat);
            prod = 64'(a_mdl) * 64'(b_mdl);
            chk($sformatf("rnd%0d_stat", it), 64'(stat), 64'({extra, 2'b10}));
            rd_chk($sformatf("rnd%0d_res_lo", it), 5'h0C, prod[31:0]);
            rd_chk($sformatf("rnd%0d_res_hi", it), 5'h10, prod[63:32]);
            axi_write(5'h08, 32'h6, 4'hf, r);
        end
        rd_chk("rnd_final_a", 5'h00, a_mdl);

        // reset in the middle of a multiply
        tb_lat = 6;
        wr_chk("midrst_ctrl", 5'h08, 32'h1, 2'b00);
        @(posedge clk);
        #3 _rst = 1'b1;
        #1 chk("midrst_outs", 64'({s_bvalid, s_rvalid, m_start, s_awready}), 64'(4'b0001));
        @(posedge clk);
        @(negedge clk) _rst = 1'b0;
        s0 = start_cnt;
        repeat (8) @(posedge clk);
        #1 chk("midrst_no_start", 64'(start_cnt - s0), 64'(0));
        rd_chk("midrst_stat", 5'h08, 32'h0);
        rd_chk("midrst_res_lo", 5'h0C, 32'h0);
        rd_chk("midrst_a", 5'h00, 32'h0);
        chk("start_one_cycle", 64'(start_long), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
